// File: rtl/lsu_if.sv
// Request/response and data-memory port bundle for load_store_unit.
// slave: the unit itself; master: requester plus memory side.
interface lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_half;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic                  mem_re;
  logic                  mem_we;
  logic                  mem_rs;
  logic                  mem_ws;
  logic [ADDR_WIDTH-1:0] mem_ra;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [31:0]           mem_wd;
  logic [31:0]           mem_rd;

  modport slave (
    input  req_valid, req_we, req_half, req_signed, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_re, mem_we, mem_rs, mem_ws, mem_ra, mem_wa, mem_wd
  );

  modport master (
    output req_valid, req_we, req_half, req_signed, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_re, mem_we, mem_rs, mem_ws, mem_ra, mem_wa, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-organised data memory.
// Optional misalignment error path: define LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, half_q, signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]           resp_data_q;
  logic                  mem_re_q, mem_we_q, mem_rs_q, mem_ws_q;
  logic [ADDR_WIDTH-1:0] mem_ra_q, mem_wa_q;
  logic [31:0]           mem_wd_q;

  logic                  req_ready_d, resp_valid_d, resp_err_d;
  logic [31:0]           resp_data_d;
  logic                  mem_re_d, mem_we_d, mem_rs_d, mem_ws_d;
  logic [ADDR_WIDTH-1:0] mem_a_d;
  logic [31:0]           mem_wd_d;

  logic                  misalign_c;
  logic [ADDR_WIDTH-1:0] addr_al_c;
  logic                  cur_we, cur_half;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           cur_wdata;
  logic [31:0]           load_fmt_c;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_c = bus.req_half ? bus.req_addr[0] : (bus.req_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign misalign_c      = 1'b0;
  assign unused_addr_lsb = bus.req_addr[0];
`endif

  // Low address bits are dropped so the memory always sees an aligned access.
  assign addr_al_c = bus.req_half ? {bus.req_addr[ADDR_WIDTH-1:1], 1'b0}
                                  : {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};

  assign load_fmt_c = !half_q   ? bus.mem_rd :
                      signed_q  ? {{16{bus.mem_rd[15]}}, bus.mem_rd[15:0]} :
                                  {16'h0000, bus.mem_rd[15:0]};

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_we       = we_q;
    cur_half     = half_q;
    cur_addr     = addr_q;
    cur_wdata    = wdata_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_half  = bus.req_half;
      cur_addr  = addr_al_c;
      cur_wdata = bus.req_wdata;
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = misalign_c ? RESP : ACCESS;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_re_d     = (state_d == ACCESS) && !cur_we;
    mem_rs_d     = mem_re_d && cur_half;
    mem_we_d     = (state_q == IDLE) && (state_d == ACCESS) && cur_we;
    mem_ws_d     = mem_we_d && cur_half;
    mem_a_d      = (state_d == ACCESS) ? cur_addr : '0;
    mem_wd_d     = '0;
    if ((state_d == ACCESS) && cur_we)
      mem_wd_d = cur_half ? {16'h0000, cur_wdata[15:0]} : cur_wdata;

    if ((state_d == RESP) && (state_q != RESP)) begin
      resp_err_d  = (state_q == IDLE);
      resp_data_d = ((state_q == ACCESS) && !we_q) ? load_fmt_c : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      half_q       <= 1'b0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_rs_q     <= 1'b0;
      mem_ws_q     <= 1'b0;
      mem_ra_q     <= '0;
      mem_wa_q     <= '0;
      mem_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      if ((state_q == IDLE) && bus.req_valid) begin
        we_q     <= bus.req_we;
        half_q   <= bus.req_half;
        signed_q <= bus.req_signed;
        addr_q   <= addr_al_c;
        wdata_q  <= bus.req_wdata;
      end
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_rs_q     <= mem_rs_d;
      mem_ws_q     <= mem_ws_d;
      mem_ra_q     <= mem_a_d;
      mem_wa_q     <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_rs     = mem_rs_q;
  assign bus.mem_ws     = mem_ws_q;
  assign bus.mem_ra     = mem_ra_q;
  assign bus.mem_wa     = mem_wa_q;
  assign bus.mem_wd     = mem_wd_q;

endmodule
